// File: rtl/id_ex_stage_pkg.sv
// Shared pipeline control-bundle types, bit positions and NOP constants for the ID/EX boundary.
package id_ex_stage_pkg;

  localparam int CTRL_EX_W  = 3;
  localparam int CTRL_MEM_W = 2;
  localparam int CTRL_WB_W  = 2;
  localparam int REG_ADDR_W = 5;
  localparam int FUNCT_W    = 4;

  // Bit positions inside each control bundle
  localparam int ALUOP_HI = 2;
  localparam int ALUOP_LO = 1;
  localparam int ALUSRC   = 0;
  localparam int MEMREAD  = 1;
  localparam int MEMWRITE = 0;
  localparam int MEMTOREG = 1;
  localparam int REGWRITE = 0;

  typedef logic [CTRL_EX_W-1:0]  ctrl_ex_t;
  typedef logic [CTRL_MEM_W-1:0] ctrl_mem_t;
  typedef logic [CTRL_WB_W-1:0]  ctrl_wb_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [FUNCT_W-1:0]    funct_t;

  localparam ctrl_ex_t  CTRL_EX_NOP  = '0;
  localparam ctrl_mem_t CTRL_MEM_NOP = '0;
  localparam ctrl_wb_t  CTRL_WB_NOP  = '0;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID-side decoded fields in, EX-side registered fields out; master is the surrounding pipeline.
interface id_ex_stage_if
  import id_ex_stage_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  ctrl_ex_t            ctrl_ex_i;
  ctrl_mem_t           ctrl_mem_i;
  ctrl_wb_t            ctrl_wb_i;
  logic [ADDR_W-1:0]   pc_i;
  logic [DATA_W-1:0]   rs1_data_i;
  logic [DATA_W-1:0]   rs2_data_i;
  logic [DATA_W-1:0]   imm_i;
  reg_addr_t           rs1_i;
  reg_addr_t           rs2_i;
  reg_addr_t           rd_i;
  funct_t              funct_i;

  ctrl_ex_t            ex_ctrl_ex_o;
  ctrl_mem_t           ex_ctrl_mem_o;
  ctrl_wb_t            ex_ctrl_wb_o;
  logic [ADDR_W-1:0]   ex_pc_o;
  logic [DATA_W-1:0]   ex_rs1_data_o;
  logic [DATA_W-1:0]   ex_rs2_data_o;
  logic [DATA_W-1:0]   ex_imm_o;
  reg_addr_t           ex_rs1_o;
  reg_addr_t           ex_rs2_o;
  reg_addr_t           ex_rd_o;
  funct_t              ex_funct_o;

  modport master (
    output ctrl_ex_i, ctrl_mem_i, ctrl_wb_i, pc_i, rs1_data_i, rs2_data_i, imm_i,
           rs1_i, rs2_i, rd_i, funct_i,
    input  ex_ctrl_ex_o, ex_ctrl_mem_o, ex_ctrl_wb_o, ex_pc_o, ex_rs1_data_o,
           ex_rs2_data_o, ex_imm_o, ex_rs1_o, ex_rs2_o, ex_rd_o, ex_funct_o
  );

  modport slave (
    input  ctrl_ex_i, ctrl_mem_i, ctrl_wb_i, pc_i, rs1_data_i, rs2_data_i, imm_i,
           rs1_i, rs2_i, rd_i, funct_i,
    output ex_ctrl_ex_o, ex_ctrl_mem_o, ex_ctrl_wb_o, ex_pc_o, ex_rs1_data_o,
           ex_rs2_data_o, ex_imm_o, ex_rs1_o, ex_rs2_o, ex_rd_o, ex_funct_o
  );
endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use detect: a load in EX whose nonzero rd matches either ID source register.
// Purely combinational; rs2 is compared even for I-type, which can only cost a spare bubble.
module id_ex_stage_hazard_detect
  import id_ex_stage_pkg::*;
(
  input  logic      ex_mem_read,
  input  reg_addr_t ex_rd,
  input  reg_addr_t rs1,
  input  reg_addr_t rs2,
  output logic      load_use
);

  assign load_use = ex_mem_read && (ex_rd != '0) && ((ex_rd == rs1) || (ex_rd == rs2));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: 1-cycle latency, hold freezes everything, flush/load-use inject a bubble.
// ID_EX_PERF_EN adds a saturating 32-bit count of load-use bubbles; otherwise stall_cnt_o is 0.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int INST_W = 32
)(
  input  logic                clk,
  input  logic                rst,
  input  logic                hold_i,
  input  logic                flush_i,
  id_ex_stage_if.slave        bus,
  output logic                stall_o,
  output logic [31:0]         stall_cnt_o
);

  // INST_W has no consumer in this stage; it only keeps parameter lists aligned across stages.
  if (INST_W < 16) begin : g_inst_w_unused
  end

  ctrl_ex_t          ctrl_ex_q;
  ctrl_mem_t         ctrl_mem_q;
  ctrl_wb_t          ctrl_wb_q;
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] rs1_data_q;
  logic [DATA_W-1:0] rs2_data_q;
  logic [DATA_W-1:0] imm_q;
  reg_addr_t         rs1_q;
  reg_addr_t         rs2_q;
  reg_addr_t         rd_q;
  funct_t            funct_q;
  logic              load_use;
  logic              bubble;

  id_ex_stage_hazard_detect u_hazard (
    .ex_mem_read (ctrl_mem_q[MEMREAD]),
    .ex_rd       (rd_q),
    .rs1         (bus.rs1_i),
    .rs2         (bus.rs2_i),
    .load_use    (load_use)
  );

  assign stall_o = load_use & ~hold_i;
  assign bubble  = flush_i | load_use;

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_ex_q  <= CTRL_EX_NOP;
      ctrl_mem_q <= CTRL_MEM_NOP;
      ctrl_wb_q  <= CTRL_WB_NOP;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      funct_q    <= '0;
    end else if (!hold_i) begin
      // Data fields load even on a bubble; with all control bits clear they are inert.
      pc_q       <= bus.pc_i;
      rs1_data_q <= bus.rs1_data_i;
      rs2_data_q <= bus.rs2_data_i;
      imm_q      <= bus.imm_i;
      rs1_q      <= bus.rs1_i;
      rs2_q      <= bus.rs2_i;
      funct_q    <= bus.funct_i;
      if (bubble) begin
        ctrl_ex_q  <= CTRL_EX_NOP;
        ctrl_mem_q <= CTRL_MEM_NOP;
        ctrl_wb_q  <= CTRL_WB_NOP;
        rd_q       <= '0;
      end else begin
        ctrl_ex_q  <= bus.ctrl_ex_i;
        ctrl_mem_q <= bus.ctrl_mem_i;
        ctrl_wb_q  <= bus.ctrl_wb_i;
        rd_q       <= bus.rd_i;
      end
    end
  end

`ifdef ID_EX_PERF_EN
  logic [31:0] stall_cnt_q;

  // Only bubbles caused by the hazard itself count; a coincident flush owns that bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (!hold_i && !flush_i && load_use && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = '0;
`endif

  assign bus.ex_ctrl_ex_o  = ctrl_ex_q;
  assign bus.ex_ctrl_mem_o = ctrl_mem_q;
  assign bus.ex_ctrl_wb_o  = ctrl_wb_q;
  assign bus.ex_pc_o       = pc_q;
  assign bus.ex_rs1_data_o = rs1_data_q;
  assign bus.ex_rs2_data_o = rs2_data_q;
  assign bus.ex_imm_o      = imm_q;
  assign bus.ex_rs1_o      = rs1_q;
  assign bus.ex_rs2_o      = rs2_q;
  assign bus.ex_rd_o       = rd_q;
  assign bus.ex_funct_o    = funct_q;

endmodule
